// File: rtl/usb3_pkg.sv
// Shared constants, symbol classification and the byte-wide LFSR advance
// for the USB 3.0 scrambler.
package usb3_pkg;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h3C;
    localparam logic [15:0] LFSR_POLY = 16'h0039;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        SYM_DATA,
        SYM_COM,
        SYM_SKP,
        SYM_KOTHER
    } sym_kind_e;

    // Eight Galois steps of x^16+x^5+x^4+x^3+1; unrolls into a flat XOR matrix.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] state);
        logic [15:0] s;
        s = state;
        for (int n = 0; n < 8; n++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? LFSR_POLY : 16'h0000);
        end
        return s;
    endfunction

    function automatic sym_kind_e sym_classify(input logic k, input logic [7:0] b);
        if (!k) begin
            return SYM_DATA;
        end
        if (b == K_COM) begin
            return SYM_COM;
        end
        if (b == K_SKP) begin
            return SYM_SKP;
        end
        return SYM_KOTHER;
    endfunction

endpackage

// File: rtl/usb3_scram_lane.sv
// One byte lane of the scrambler: applies the keystream to D symbols and
// works out the LFSR state handed on to the next lane.
module usb3_scram_lane
    import usb3_pkg::*;
(
    input  logic [15:0] state_in,
    input  logic [7:0]  byte_in,
    input  logic        k,
    input  logic        dis,
    input  logic [15:0] seed,
    output logic [7:0]  byte_out,
    output logic [15:0] state_out
);

    sym_kind_e   w_kind;
    logic [7:0]  w_key;
    logic [15:0] w_adv;

    assign w_kind = sym_classify(k, byte_in);
    assign w_adv  = lfsr_adv8(state_in);

    // Keystream bit i comes from state bit 15-i of the pre-advance state.
    always_comb begin
        w_key = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_key[i] = state_in[15-i];
        end
    end

    // Bypass only affects the data path; the state chain behaves identically.
    always_comb begin
        byte_out  = byte_in;
        state_out = w_adv;
        case (w_kind)
            SYM_COM:    state_out = seed;
            SYM_SKP:    state_out = state_in;
            SYM_KOTHER: state_out = w_adv;
            default: begin
                if (!dis) begin
                    byte_out = byte_in ^ w_key;
                end
            end
        endcase
    end

endmodule

// File: rtl/usb3_scrambler_gen.sv
// USB 3.0 PIPE scrambler/descrambler: DATA_W/8 lanes chained through one
// LFSR per clock, with a single registered output stage.
module usb3_scrambler_gen
    import usb3_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [15:0] SEED   = LFSR_SEED
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] datak_in,
    input  logic                in_valid,
    input  logic                scram_rst,
    input  logic                scram_dis,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W/8-1:0] datak_out,
    output logic                out_valid
);

    localparam int L = DATA_W / 8;

    logic [L:0][15:0]   w_state;
    logic [DATA_W-1:0]  w_data;

    logic [15:0]        r_lfsr;
    logic [DATA_W-1:0]  r_data;
    logic [L-1:0]       r_datak;
    logic               r_valid;

    assign w_state[0] = scram_rst ? SEED : r_lfsr;

    for (genvar g = 0; g < L; g++) begin : g_lane
        usb3_scram_lane u_lane (
            .state_in  (w_state[g]),
            .byte_in   (data_in[g*8 +: 8]),
            .k         (datak_in[g]),
            .dis       (scram_dis),
            .seed      (SEED),
            .byte_out  (w_data[g*8 +: 8]),
            .state_out (w_state[g+1])
        );
    end

    // An idle cycle holds everything except that scram_rst may still reload the seed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr  <= SEED;
            r_data  <= '0;
            r_datak <= '0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_lfsr  <= w_state[L];
            r_data  <= w_data;
            r_datak <= datak_in;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            if (scram_rst) begin
                r_lfsr <= SEED;
            end
        end
    end

    assign data_out  = r_data;
    assign datak_out = r_datak;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_usb3_scrambler_gen.sv
// Directed bench for usb3_scrambler_gen: hand-computed keystream vectors on
// 8- and 32-bit instances, plus scramble/descramble round trips at all widths.
module tb_usb3_scrambler_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dataIn;
    logic [3:0]  datakIn;
    logic        inValid;
    logic        scramRst;
    logic        scramDis;
    logic [31:0] dataOut;
    logic [3:0]  datakOut;
    logic        outValid;

    logic        rtReset;
    logic [63:0] rtData;
    logic [7:0]  rtK;
    logic        rtValid;

    logic [7:0]  s8Data,  d8Data;
    logic [0:0]  s8K,     d8K;
    logic        s8V,     d8V;
    logic [15:0] s16Data, d16Data;
    logic [1:0]  s16K,    d16K;
    logic        s16V,    d16V;
    logic [31:0] s32Data, d32Data;
    logic [3:0]  s32K,    d32K;
    logic        s32V,    d32V;
    logic [63:0] s64Data, d64Data;
    logic [7:0]  s64K,    d64K;
    logic        s64V,    d64V;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    usb3_scrambler_gen #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .data_in(dataIn), .datak_in(datakIn),
        .in_valid(inValid), .scram_rst(scramRst), .scram_dis(scramDis),
        .data_out(dataOut), .datak_out(datakOut), .out_valid(outValid)
    );

    usb3_scrambler_gen #(.DATA_W(8)) s8 (
        .clock(clock), .reset(rtReset), .data_in(rtData[7:0]), .datak_in(rtK[0:0]),
        .in_valid(rtValid), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(s8Data), .datak_out(s8K), .out_valid(s8V)
    );
    usb3_scrambler_gen #(.DATA_W(8)) d8 (
        .clock(clock), .reset(rtReset), .data_in(s8Data), .datak_in(s8K),
        .in_valid(s8V), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(d8Data), .datak_out(d8K), .out_valid(d8V)
    );
    usb3_scrambler_gen #(.DATA_W(16)) s16 (
        .clock(clock), .reset(rtReset), .data_in(rtData[15:0]), .datak_in(rtK[1:0]),
        .in_valid(rtValid), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(s16Data), .datak_out(s16K), .out_valid(s16V)
    );
    usb3_scrambler_gen #(.DATA_W(16)) d16 (
        .clock(clock), .reset(rtReset), .data_in(s16Data), .datak_in(s16K),
        .in_valid(s16V), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(d16Data), .datak_out(d16K), .out_valid(d16V)
    );
    usb3_scrambler_gen #(.DATA_W(32)) s32 (
        .clock(clock), .reset(rtReset), .data_in(rtData[31:0]), .datak_in(rtK[3:0]),
        .in_valid(rtValid), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(s32Data), .datak_out(s32K), .out_valid(s32V)
    );
    usb3_scrambler_gen #(.DATA_W(32)) d32 (
        .clock(clock), .reset(rtReset), .data_in(s32Data), .datak_in(s32K),
        .in_valid(s32V), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(d32Data), .datak_out(d32K), .out_valid(d32V)
    );
    usb3_scrambler_gen #(.DATA_W(64)) s64 (
        .clock(clock), .reset(rtReset), .data_in(rtData), .datak_in(rtK),
        .in_valid(rtValid), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(s64Data), .datak_out(s64K), .out_valid(s64V)
    );
    usb3_scrambler_gen #(.DATA_W(64)) d64 (
        .clock(clock), .reset(rtReset), .data_in(s64Data), .datak_in(s64K),
        .in_valid(s64V), .scram_rst(1'b0), .scram_dis(1'b0),
        .data_out(d64Data), .datak_out(d64K), .out_valid(d64V)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic v,
                                 input logic rst, input logic dis);
        dataIn   = d;
        datakIn  = k;
        inValid  = v;
        scramRst = rst;
        scramDis = dis;
        tick();
    endtask

    task automatic checkDut(input string tag, input logic [31:0] expData,
                            input logic [3:0] expK, input logic expValid);
        checkOutput({tag, ".data"},  80'(dataOut),  80'(expData));
        checkOutput({tag, ".datak"}, 80'(datakOut), 80'(expK));
        checkOutput({tag, ".valid"}, 80'(outValid), 80'(expValid));
    endtask

    task automatic checkS8(input string tag, input logic [7:0] expData,
                           input logic expK, input logic expValid);
        checkOutput(tag, 80'({s8V, s8K, s8Data}), 80'({expValid, expK, expData}));
    endtask

    logic [63:0] rndData, prevData;
    logic [7:0]  rndK, prevK;
    int          sel;

    initial begin
        reset    = 1'b1;
        dataIn   = 32'h0;
        datakIn  = 4'h0;
        inValid  = 1'b0;
        scramRst = 1'b0;
        scramDis = 1'b0;
        rtReset  = 1'b1;
        rtData   = 64'h0;
        rtK      = 8'h0;
        rtValid  = 1'b1;
        rndData  = 64'h0;
        rndK     = 8'h0;
        prevData = 64'h0;
        prevK    = 8'h0;
        sel      = 0;

        // 8-bit serial keystream after a COM: FF 17 C0 14.
        tick();
        checkS8("w8.reset", 8'h00, 1'b0, 1'b0);
        rtReset = 1'b0;
        rtData = 64'hBC; rtK = 8'h01; tick();
        checkS8("w8.com", 8'hBC, 1'b1, 1'b1);
        rtData = 64'h0; rtK = 8'h00;
        tick(); checkS8("w8.d0", 8'hFF, 1'b0, 1'b1);
        tick(); checkS8("w8.d1", 8'h17, 1'b0, 1'b1);
        tick(); checkS8("w8.d2", 8'hC0, 1'b0, 1'b1);
        tick(); checkS8("w8.d3", 8'h14, 1'b0, 1'b1);
        rtValid = 1'b0;

        applyStimulus(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        checkDut("reset", 32'h0, 4'h0, 1'b0);
        reset = 1'b0;

        applyStimulus(32'h000000BC, 4'h1, 1'b1, 1'b0, 1'b0);
        checkDut("com_lane0", 32'hC017FFBC, 4'h1, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("after_com", 32'h02E7B214, 4'h0, 1'b1);
        applyStimulus(32'hBC000000, 4'h8, 1'b1, 1'b0, 1'b0);
        checkDut("com_lane3", 32'hBC6E7282, 4'h8, 1'b1);
        applyStimulus(32'h003C3C00, 4'h6, 1'b1, 1'b0, 1'b0);
        checkDut("skp_mid", 32'h173C3CFF, 4'h6, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("after_skp", 32'hE7B214C0, 4'h0, 1'b1);

        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1);
        checkDut("bypass0", 32'h00000000, 4'h0, 1'b1);
        applyStimulus(32'h00BC0000, 4'h4, 1'b1, 1'b0, 1'b1);
        checkDut("bypass1", 32'h00BC0000, 4'h4, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1);
        checkDut("bypass2", 32'h00000000, 4'h0, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("reenable", 32'h728202E7, 4'h0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0);
            checkDut("stall", 32'h728202E7, 4'h0, 1'b0);
        end
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("resume", 32'hBEA6286E, 4'h0, 1'b1);

        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0);
        checkDut("rst_valid", 32'h14C017FF, 4'h0, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b0, 1'b1, 1'b0);
        checkDut("rst_idle", 32'h14C017FF, 4'h0, 1'b0);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("after_rst_idle", 32'h14C017FF, 4'h0, 1'b1);
        applyStimulus(32'h3C3C3C3C, 4'hF, 1'b1, 1'b0, 1'b0);
        checkDut("all_skp", 32'h3C3C3C3C, 4'hF, 1'b1);
        applyStimulus(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("after_all_skp", 32'h8202E7B2, 4'h0, 1'b1);
        applyStimulus(32'h00F70000, 4'h4, 1'b1, 1'b0, 1'b0);
        checkDut("k_other", 32'hA6F76E72, 4'h4, 1'b1);

        reset = 1'b1;
        applyStimulus(32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 1'b0);
        checkDut("reset_mid", 32'h0, 4'h0, 1'b0);
        reset = 1'b0;
        applyStimulus(32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b0);
        checkDut("after_reset", 32'hEB3FE800, 4'h0, 1'b1);

        // Round trip: descrambled output must equal the word sent two cycles earlier.
        rtReset = 1'b1;
        rtValid = 1'b0;
        tick();
        rtReset = 1'b0;
        rtValid = 1'b1;
        for (int n = 0; n < 120; n++) begin
            for (int l = 0; l < 8; l++) begin
                sel = int'($urandom_range(0, 9));
                case (sel)
                    0:       begin rndData[l*8 +: 8] = 8'hBC; rndK[l] = 1'b1; end
                    1:       begin rndData[l*8 +: 8] = 8'h3C; rndK[l] = 1'b1; end
                    2:       begin rndData[l*8 +: 8] = 8'hF7; rndK[l] = 1'b1; end
                    default: begin rndData[l*8 +: 8] = 8'($urandom_range(0, 255)); rndK[l] = 1'b0; end
                endcase
            end
            rtData = rndData;
            rtK    = rndK;
            tick();
            if (n == 0) begin
                checkOutput("rt.latency", 80'(d32V), 80'(1'b0));
            end else begin
                checkOutput("rt8",  80'({d8V,  d8K,  d8Data}),  80'({1'b1, prevK[0:0], prevData[7:0]}));
                checkOutput("rt16", 80'({d16V, d16K, d16Data}), 80'({1'b1, prevK[1:0], prevData[15:0]}));
                checkOutput("rt32", 80'({d32V, d32K, d32Data}), 80'({1'b1, prevK[3:0], prevData[31:0]}));
                checkOutput("rt64", 80'({d64V, d64K, d64Data}), 80'({1'b1, prevK, prevData}));
            end
            prevData = rndData;
            prevK    = rndK;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
